// File: rtl/exp_pkg.sv
// rtl/exp_pkg.sv - shared types and widths for the exponent job dispatcher
package exp_pkg;

    localparam int EXP_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2,
        HOLD      = 2'd3
    } state_t;

    typedef struct packed {
        logic [EXP_WIDTH-1:0] a;
        logic [EXP_WIDTH-1:0] x;
    } exp_job_t;

endpackage

// File: rtl/exp_job_fifo.sv
// rtl/exp_job_fifo.sv - DEPTH-entry job FIFO with registered occupancy count
module exp_job_fifo
    import exp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     push,
    input  exp_job_t push_job,
    input  logic     pop,
    output exp_job_t head_job,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    exp_job_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign head_job = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

    // Storage needs no reset; occupancy alone defines which entries are live.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_job;
    end

endmodule

// File: rtl/exp_job_dispatcher.sv
// rtl/exp_job_dispatcher.sv - queues (a, x) jobs, runs the exponent core one at a time; optional EXP_DISPATCH_STATS_EN
module exp_job_dispatcher
    import exp_pkg::*;
#(
    parameter int WIDTH = EXP_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_x,
    output logic             in_ready,
    output logic             core_enable,
    output logic [WIDTH-1:0] core_a,
    output logic [WIDTH-1:0] core_x,
    input  logic             core_ready,
    input  logic [WIDTH-1:0] core_p,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_p,
    input  logic             out_ready
`ifdef EXP_DISPATCH_STATS_EN
    ,
    output logic [31:0]      stat_jobs,
    output logic [31:0]      stat_busy
`endif
);

    state_t   state;
    state_t   state_next;
    exp_job_t push_job;
    exp_job_t head_job;
    logic     fifo_full;
    logic     fifo_empty;
    logic     fifo_push;
    logic     job_pop;
    logic     load_result;
    logic     result_taken;

    // Held low while reset is asserted so nothing is accepted into a FIFO being cleared.
    assign in_ready   = !reset && !fifo_full;
    assign fifo_push  = in_valid && in_ready;
    assign push_job.a = in_a;
    assign push_job.x = in_x;

    exp_job_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (fifo_push),
        .push_job (push_job),
        .pop      (job_pop),
        .head_job (head_job),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state: start, see the core go busy, see it finish, wait for the result to be taken.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (!fifo_empty && core_ready) state_next = WAIT_BUSY;
            WAIT_BUSY: if (!core_ready)               state_next = WAIT_DONE;
            WAIT_DONE: if (core_ready)                state_next = HOLD;
            HOLD:      if (out_ready)                 state_next = IDLE;
            default:                                  state_next = IDLE;
        endcase
    end

    // Control strobes decoded from the current state.
    always_comb begin
        job_pop      = (state == IDLE) && !fifo_empty && core_ready;
        load_result  = (state == WAIT_DONE) && core_ready;
        result_taken = (state == HOLD) && out_ready;
    end

    // Core operands stay put from the start pulse until the next job is popped.
    always_ff @(posedge clock) begin
        if (reset) begin
            core_enable <= 1'b0;
            core_a      <= '0;
            core_x      <= '0;
            out_valid   <= 1'b0;
            out_p       <= '0;
        end else begin
            core_enable <= job_pop;
            if (job_pop) begin
                core_a <= head_job.a;
                core_x <= head_job.x;
            end
            if (load_result) begin
                out_p     <= core_p;
                out_valid <= 1'b1;
            end else if (result_taken) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef EXP_DISPATCH_STATS_EN
    // Job count wraps; busy-cycle count sticks at all-ones.
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_jobs <= '0;
            stat_busy <= '0;
        end else begin
            if (result_taken) stat_jobs <= stat_jobs + 32'd1;
            if ((state != IDLE) && (stat_busy != 32'hFFFF_FFFF)) stat_busy <= stat_busy + 32'd1;
        end
    end
`endif

endmodule
